spi_shift_engine: RTL and testbench

Parametrised SPI shift engine, next generation of the 8-bit load/shift register. Adds configurable width, MSB/LSB-first order, a bit counter with transfer framing (busy/done), a received-word holding register, load-while-busy error flagging, abort, and a defined idle output level. Sits between the SPI bit-clock edge generator (which supplies single-cycle shift strobes) and the byte/word-level SPI controller.

---
 rtl/spi_shift_engine.sv | 115 +++++++++++
 tb/tb_spi_shift_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI shift engine: parameterised load/shift register with transfer framing.
// A loaded word is shifted out one bit per shift strobe while serial input
// bits are shifted in. After WIDTH shifts the received word is latched into
// rx_data and done pulses. Abort cancels a transfer and keeps the register.
module spi_shift_engine #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             in,
  input  logic             abort,
  output logic             out,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shr_q, shr_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   shifted;

  // One shift step in the configured direction with the new serial bit.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] s,
                                                  input logic b);
    if (MSB_FIRST) shift_step = {s[WIDTH-2:0], b};
    else           shift_step = {b, s[WIDTH-1:1]};
  endfunction

  // Next register value if the current cycle carries a shift strobe.
  always_comb begin
    shifted = shift_step(shr_q, in);
  end

  // Next-state logic; abort overrides load and shift, load beats shift in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shr_d   = din;
            cnt_d   = '0;
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (load) err_d = 1'b1;
          if (shift) begin
            shr_d = shifted;
            if (cnt_q == LAST_BIT) begin
              rx_d    = shifted;
              cnt_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, data and pulse registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shr_q   <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign out      = busy ? (MSB_FIRST ? shr_q[WIDTH-1] : shr_q[0]) : IDLE_LEVEL;
  assign dout     = shr_q;
  assign rx_data  = rx_q;
  assign done     = done_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: three configurations (8-bit MSB-first,
// 8-bit LSB-first, 16-bit MSB-first) share stimulus; one is selected and
// compared every cycle against a word-level reference model.
module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0, shift = 1'b0, in = 1'b0, abort = 1'b0;
  logic [31:0] din = '0;

  logic        out_a, busy_a, done_a, err_a;
  logic [7:0]  dout_a, rx_a;
  logic        out_b, busy_b, done_b, err_b;
  logic [7:0]  dout_b, rx_b;
  logic        out_c, busy_c, done_c, err_c;
  logic [15:0] dout_c, rx_c;

  always #5 clk = ~clk;

  spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst(rst), .load(load), .din(din[7:0]), .shift(shift), .in(in),
    .abort(abort), .out(out_a), .dout(dout_a), .rx_data(rx_a), .busy(busy_a),
    .done(done_a), .load_err(err_a));

  spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
    .clk(clk), .rst(rst), .load(load), .din(din[7:0]), .shift(shift), .in(in),
    .abort(abort), .out(out_b), .dout(dout_b), .rx_data(rx_b), .busy(busy_b),
    .done(done_b), .load_err(err_b));

  spi_shift_engine #(.WIDTH(16), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .rst(rst), .load(load), .din(din[15:0]), .shift(shift), .in(in),
    .abort(abort), .out(out_c), .dout(dout_c), .rx_data(rx_c), .busy(busy_c),
    .done(done_c), .load_err(err_c));

  // Selected instance viewed through 32-bit generic signals
  int          sel = 0;
  logic        g_out, g_busy, g_done, g_err;
  logic [31:0] g_dout, g_rx;

  always_comb begin
    g_out = out_a; g_busy = busy_a; g_done = done_a; g_err = err_a;
    g_dout = {24'b0, dout_a}; g_rx = {24'b0, rx_a};
    if (sel == 1) begin
      g_out = out_b; g_busy = busy_b; g_done = done_b; g_err = err_b;
      g_dout = {24'b0, dout_b}; g_rx = {24'b0, rx_b};
    end else if (sel == 2) begin
      g_out = out_c; g_busy = busy_c; g_done = done_c; g_err = err_c;
      g_dout = {16'b0, dout_c}; g_rx = {16'b0, rx_c};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cfg %0d): got %h expected %h", tag, sel, obs, exp);
    end
  endtask

  // Reference model: the transfer is described by the loaded word, how many
  // bits have gone out and the list of bits received so far.
  int          w;
  bit          msb;
  logic [31:0] mask;
  bit          m_busy, m_done, m_err;
  int          m_k;
  logic [31:0] m_tx, m_shr, m_rx;
  bit          m_rxq[$];

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_k = 0;
    m_tx = '0; m_shr = '0; m_rx = '0;
    m_rxq.delete();
  endtask

  task automatic set_cfg(input int s);
    sel  = s;
    w    = (s == 2) ? 16 : 8;
    msb  = (s != 1);
    mask = (32'h1 << w) - 32'h1;
  endtask

  function automatic logic [31:0] assemble();
    logic [31:0] r = '0;
    for (int j = 0; j < m_rxq.size(); j++)
      if (m_rxq[j]) r = r + (32'h1 << (msb ? (w - 1 - j) : j));
    return r;
  endfunction

  task automatic model_edge();
    m_done = 0;
    m_err  = 0;
    if (abort) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (load) begin
        m_tx = din & mask; m_shr = m_tx; m_k = 0; m_busy = 1; m_rxq.delete();
      end
    end else begin
      if (load) m_err = 1;
      if (shift) begin
        m_rxq.push_back(in);
        if (msb) m_shr = ((m_shr * 2) + 32'(in)) & mask;
        else     m_shr = (m_shr / 2) + (in ? (32'h1 << (w - 1)) : 32'h0);
        m_k++;
        if (m_k == w) begin
          m_busy = 0; m_rx = assemble(); m_done = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic eo;
    eo = m_busy ? m_tx[msb ? (w - 1 - m_k) : m_k] : 1'b0;
    chk("out", 32'(g_out), 32'(eo));
    chk("dout", g_dout, m_shr);
    chk("busy", 32'(g_busy), 32'(m_busy));
    chk("done", 32'(g_done), 32'(m_done));
    chk("load_err", 32'(g_err), 32'(m_err));
    chk("rx_data", g_rx, m_rx);
  endtask

  task automatic step(input logic ld, input logic [31:0] d, input logic sh,
                      input logic b, input logic ab);
    @(negedge clk);
    load = ld; din = d; shift = sh; in = b; abort = ab;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    load = 0; shift = 0; in = 0; abort = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic shifts(input int n, input logic [31:0] bits);
    for (int i = 0; i < n; i++) step(0, 0, 1, bits[n - 1 - i], 0);
  endtask

  initial begin
    set_cfg(0);
    model_reset();
    #12 compare_all();
    chk("reset_dout", g_dout, 32'h0);
    @(negedge clk); rst = 1'b1;

    // MSB-first word with mixed serial input
    step(1, 32'hA5, 0, 0, 0);
    shifts(8, 32'b01100111);
    chk("rx_67", g_rx, 32'h67);
    step(0, 0, 0, 0, 0);

    // Load while busy is rejected, transfer carries on
    step(1, 32'h3C, 0, 0, 0);
    shifts(3, 32'b000);
    step(1, 32'h99, 0, 0, 0);
    chk("err_pulse", 32'(g_err), 32'h1);
    step(0, 0, 0, 0, 0);
    chk("err_clear", 32'(g_err), 32'h0);
    shifts(5, 32'b00000);
    chk("rx_3c", g_rx, 32'h00);

    // Abort mid-transfer, then a clean transfer
    step(1, 32'hF0, 0, 0, 0);
    shifts(4, 32'b1111);
    step(0, 0, 1, 1, 1);
    chk("abort_busy", 32'(g_busy), 32'h0);
    chk("abort_rx", g_rx, 32'h00);
    step(1, 32'h81, 0, 0, 0);
    shifts(8, 32'hFF);
    chk("rx_81", g_rx, 32'hFF);

    // Idle shifts ignored; load and shift together in idle loads
    shifts(3, 32'b101);
    step(1, 32'h5A, 1, 1, 0);
    chk("ld_sh_dout", g_dout, 32'h5A);

    // Asynchronous reset in the middle of a transfer
    shifts(5, 32'b10101);
    do_reset();
    chk("async_busy", 32'(g_busy), 32'h0);
    chk("async_rx", g_rx, 32'h0);

    // LSB-first, back-to-back load in the done cycle
    set_cfg(1);
    do_reset();
    step(1, 32'hA5, 0, 0, 0);
    shifts(8, 32'hFF);
    chk("rx_ff_lsb", g_rx, 32'hFF);
    step(1, 32'h3C, 0, 0, 0);
    chk("b2b_busy", 32'(g_busy), 32'h1);
    shifts(8, 32'h0F);

    // 16-bit configuration
    set_cfg(2);
    do_reset();
    step(1, 32'h1234, 0, 0, 0);
    shifts(16, 32'h0);
    chk("rx_16", g_rx, 32'h0);

    // Randomised traffic on each configuration
    for (int c = 0; c < 3; c++) begin
      set_cfg(c);
      do_reset();
      for (int i = 0; i < 400; i++)
        step($urandom_range(0, 99) < 12, $urandom, $urandom_range(0, 99) < 45,
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
